mos_switch_eval: RTL and testbench

- Clocked, lane-parallel evaluator of switch-level nmos and pmos transistor behaviour over the simulator's six-valued logic set (0, 1, X, Z, L, H).
- Each lane takes a data value and a gate (control) value. Per lane it produces the registered nmos output and the registered pmos output.
- Sits in the gate-evaluation datapath and replaces per-primitive combinational lookup with a pipelined table evaluator.

---
 rtl/mos_switch_eval.sv | 90 +++++++++
 tb/tb_mos_switch_eval.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mos_switch_eval.sv
// mos_switch_eval: lane-parallel, single-cycle-latency evaluator of
// switch-level nmos/pmos behaviour over the six-valued set
// 0, 1, X, Z, L, H (codes 0..5; codes 6 and 7 read as X).
//
// Handshake: valid-only, no backpressure. A sample is accepted on every
// rising clk edge where in_valid=1. Its results appear on nmos_out/pmos_out
// one edge later, with out_valid=1 for that cycle. When in_valid=0 the
// result registers hold and out_valid drops to 0.
module mos_switch_eval #(
  parameter int LANES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [3*LANES-1:0] data_in,
  input  logic [3*LANES-1:0] gate_in,
  output logic               out_valid,
  output logic [3*LANES-1:0] nmos_out,
  output logic [3*LANES-1:0] pmos_out
);

  localparam logic [2:0] V0 = 3'd0;
  localparam logic [2:0] V1 = 3'd1;
  localparam logic [2:0] VX = 3'd2;
  localparam logic [2:0] VZ = 3'd3;
  localparam logic [2:0] VL = 3'd4;
  localparam logic [2:0] VH = 3'd5;

  // Illegal codes collapse to X before any evaluation.
  function automatic logic [2:0] legalize(input logic [2:0] v);
    legalize = (v > VH) ? VX : v;
  endfunction

  // One switch. on_code is the gate value that turns the device on; the
  // other strong gate value turns it off; anything else leaves the gate
  // unknown, so a strong data value can only be claimed as "value-or-Z".
  function automatic logic [2:0] eval_switch(input logic [2:0] data,
                                             input logic [2:0] gate,
                                             input logic [2:0] on_code,
                                             input logic [2:0] off_code);
    logic [2:0] d;
    d = legalize(data);
    if (gate == on_code) begin
      eval_switch = d;
    end else if (gate == off_code) begin
      eval_switch = VZ;
    end else begin
      case (d)
        V0:      eval_switch = VL;
        V1:      eval_switch = VH;
        default: eval_switch = d;
      endcase
    end
  endfunction

  logic               valid_q, valid_d;
  logic [3*LANES-1:0] nmos_q, nmos_d;
  logic [3*LANES-1:0] pmos_q, pmos_d;

  // Next-state: evaluate every lane when a sample is offered, else hold.
  always_comb begin
    valid_d = in_valid;
    nmos_d  = nmos_q;
    pmos_d  = pmos_q;
    if (in_valid) begin
      for (int k = 0; k < LANES; k++) begin
        nmos_d[3*k +: 3] = eval_switch(data_in[3*k +: 3], gate_in[3*k +: 3], V1, V0);
        pmos_d[3*k +: 3] = eval_switch(data_in[3*k +: 3], gate_in[3*k +: 3], V0, V1);
      end
    end
  end

  // Result registers; reset drives every lane to Z and drops out_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      nmos_q  <= {LANES{VZ}};
      pmos_q  <= {LANES{VZ}};
    end else begin
      valid_q <= valid_d;
      nmos_q  <= nmos_d;
      pmos_q  <= pmos_d;
    end
  end

  assign out_valid = valid_q;
  assign nmos_out  = nmos_q;
  assign pmos_out  = pmos_q;

endmodule

// File: tb/tb_mos_switch_eval.sv
// Directed bench for mos_switch_eval with four lanes: expected results are
// queued when a sample is driven and compared one edge later.
module tb_mos_switch_eval;

  localparam int LANES = 4;
  localparam int W     = 3 * LANES;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] gate_in = '0;
  logic         out_valid;
  logic [W-1:0] nmos_out;
  logic [W-1:0] pmos_out;

  int checks = 0;
  int errors = 0;

  // Expected {out_valid, nmos, pmos} per driven cycle.
  logic [2*W:0] exp_q[$];

  // Model state mirrors the result registers' hold behaviour.
  logic [W-1:0] m_nmos = {LANES{3'd3}};
  logic [W-1:0] m_pmos = {LANES{3'd3}};

  // Reference tables indexed by data code.
  logic [2:0] on_map  [8];
  logic [2:0] unk_map [8];

  mos_switch_eval #(.LANES(LANES)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .gate_in   (gate_in),
    .out_valid (out_valid),
    .nmos_out  (nmos_out),
    .pmos_out  (pmos_out)
  );

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] model(input logic [2:0] d, input logic [2:0] g, input bit is_pmos);
    logic on, off;
    on  = is_pmos ? (g == 3'd0) : (g == 3'd1);
    off = is_pmos ? (g == 3'd1) : (g == 3'd0);
    if (on)       return on_map[d];
    else if (off) return 3'd3;
    else          return unk_map[d];
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, queue the expectation, compare after the edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic [W-1:0] g);
    logic [2*W:0] e;
    @(negedge clk);
    in_valid = v;
    data_in  = d;
    gate_in  = g;
    if (v) begin
      for (int k = 0; k < LANES; k++) begin
        m_nmos[3*k +: 3] = model(d[3*k +: 3], g[3*k +: 3], 1'b0);
        m_pmos[3*k +: 3] = model(d[3*k +: 3], g[3*k +: 3], 1'b1);
      end
    end
    exp_q.push_back({v, m_nmos, m_pmos});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("out_valid", W'(out_valid), W'(e[2*W]));
    check("nmos_out", nmos_out, e[2*W-1:W]);
    check("pmos_out", pmos_out, e[W-1:0]);
  endtask

  // Lane 0 carries (d,g); other lanes carry random codes 0..7.
  function automatic logic [W-1:0] pack0(input logic [2:0] v);
    logic [W-1:0] r;
    for (int k = 1; k < LANES; k++) r[3*k +: 3] = 3'($urandom_range(0, 7));
    r[2:0] = v;
    return r;
  endfunction

  // Directed lane-0 check against hand-written table values.
  task automatic spot(input string tag, input logic [2:0] d, input logic [2:0] g,
                      input logic [2:0] en, input logic [2:0] ep);
    step(1'b1, pack0(d), pack0(g));
    check({tag, "_nmos"}, W'(nmos_out[2:0]), W'(en));
    check({tag, "_pmos"}, W'(pmos_out[2:0]), W'(ep));
  endtask

  initial begin
    on_map  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd2, 3'd2};
    unk_map = '{3'd4, 3'd5, 3'd2, 3'd3, 3'd4, 3'd5, 3'd2, 3'd2};

    // Asynchronous reset between edges.
    #2 reset = 1'b1;
    #1;
    check("rst_async_valid", W'(out_valid), '0);
    check("rst_async_nmos", nmos_out, {LANES{3'd3}});
    check("rst_async_pmos", pmos_out, {LANES{3'd3}});
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, '0, '0);
    step(1'b0, '0, '0);

    // Exhaustive sweep on lane 0.
    for (int d = 0; d < 6; d++)
      for (int g = 0; g < 6; g++)
        step(1'b1, pack0(3'(d)), pack0(3'(g)));

    // Spot and illegal-code checks.
    spot("d1g1", 3'd1, 3'd1, 3'd1, 3'd3);
    spot("d0g0", 3'd0, 3'd0, 3'd3, 3'd0);
    spot("d0g2", 3'd0, 3'd2, 3'd4, 3'd4);
    spot("d1g3", 3'd1, 3'd3, 3'd5, 3'd5);
    spot("d3g1", 3'd3, 3'd1, 3'd3, 3'd3);
    spot("d4g5", 3'd4, 3'd5, 3'd4, 3'd4);
    spot("d6g1", 3'd6, 3'd1, 3'd2, 3'd3);
    spot("d1g7", 3'd1, 3'd7, 3'd5, 3'd5);
    spot("d7g0", 3'd7, 3'd0, 3'd3, 3'd2);

    // Hold: a non-valid cycle keeps the previous result.
    spot("hold_load", 3'd1, 3'd1, 3'd1, 3'd3);
    step(1'b0, '0, '0);
    check("hold_nmos", W'(nmos_out[2:0]), W'(3'd1));
    check("hold_valid", W'(out_valid), '0);

    // Multi-lane: (1,1) (0,0) (2,1) (1,2) on lanes 0..3.
    step(1'b1, {3'd1, 3'd2, 3'd0, 3'd1}, {3'd2, 3'd1, 3'd0, 3'd1});
    check("lanes_nmos", nmos_out, {3'd5, 3'd2, 3'd3, 3'd1});
    check("lanes_pmos", pmos_out, {3'd5, 3'd3, 3'd0, 3'd3});

    // Reset mid-stream: in-flight sample is discarded.
    step(1'b1, pack0(3'd1), pack0(3'd1));
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = {LANES{3'd0}};
    gate_in  = {LANES{3'd1}};
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", W'(out_valid), '0);
    check("mid_rst_nmos", nmos_out, {LANES{3'd3}});
    check("mid_rst_pmos", pmos_out, {LANES{3'd3}});
    @(posedge clk);
    #1;
    check("mid_rst_edge_nmos", nmos_out, {LANES{3'd3}});
    m_nmos = {LANES{3'd3}};
    m_pmos = {LANES{3'd3}};
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, {LANES{3'd5}}, {LANES{3'd1}});
    check("post_rst_nmos", nmos_out, {LANES{3'd5}});
    step(1'b0, '0, '0);

    check("queue_empty", W'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
